// File: rtl/panda_muldiv_pkg.sv
// Shared types and operator-decode helpers for the iterative RV32M multiply/divide unit.
package panda_muldiv_pkg;

  // M-extension operations, in decode order.
  typedef enum logic [2:0] {
    MD_MUL,
    MD_MULH,
    MD_MULHSU,
    MD_MULHU,
    MD_DIV,
    MD_DIVU,
    MD_REM,
    MD_REMU
  } md_operator_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } md_state_e;

  function automatic logic md_is_div(input md_operator_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(input md_operator_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // Operand a is interpreted as two's complement.
  function automatic logic md_a_signed(input md_operator_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // Operand b is interpreted as two's complement.
  function automatic logic md_b_signed(input md_operator_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/panda_muldiv_if.sv
// Request/response handshake bundle between decode and the multiply/divide unit.
interface panda_muldiv_if #(
  parameter int Width = 32
);
  import panda_muldiv_pkg::*;

  logic             valid_i;
  logic             ready_o;
  md_operator_e     operator_i;
  logic [Width-1:0] operand_a_i;
  logic [Width-1:0] operand_b_i;
  logic             valid_o;
  logic             ready_i;
  logic [Width-1:0] result_o;

  // Issuing side: decode / testbench.
  modport master (
    output valid_i,
    output operator_i,
    output operand_a_i,
    output operand_b_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  result_o
  );

  // The multiply/divide unit.
  modport slave (
    input  valid_i,
    input  operator_i,
    input  operand_a_i,
    input  operand_b_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output result_o
  );

endinterface

// File: rtl/panda_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit. Multiply and divide share one
// 2*Width accumulator and one Width+1-bit adder, one bit per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | ready_o high; waiting for a request
//   MD_CALC | Width shift-add (mul) or restoring-divide iterations
//   MD_FIX  | sign correction and result select, one cycle
//   MD_DONE | valid_o high, result held until ready_i
module panda_muldiv
  import panda_muldiv_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  panda_muldiv_if.slave md
);

  localparam int CntW = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);
  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

  md_state_e        state_q;
  md_operator_e     op_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [2*Width-1:0] acc_q;
  logic [Width-1:0] opb_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] result_q;
  logic             valid_q;
  logic             ready_q;

  // Acceptance-time decode of the incoming request.
  logic             in_sign_a;
  logic             in_sign_b;
  logic [Width-1:0] in_abs_a;
  logic [Width-1:0] in_abs_b;
  logic             in_special;
  logic [Width-1:0] in_special_res;

  // Shared datapath.
  logic             is_div;
  logic [Width:0]   div_cand;
  logic [Width:0]   add_a;
  logic [Width:0]   add_b;
  logic             add_cin;
  logic [Width:0]   add_sum;
  logic [2*Width-1:0] acc_next;

  // Sign-corrected results.
  logic             neg_res;
  logic [2*Width-1:0] product;
  logic [Width-1:0] quot_mag;
  logic [Width-1:0] rem_mag;
  logic [Width-1:0] quotient;
  logic [Width-1:0] remainder;
  logic [Width-1:0] fix_result;

  assign md.ready_o  = ready_q;
  assign md.valid_o  = valid_q;
  assign md.result_o = result_q;

  // Decode signs, magnitudes and the divide corner cases of the incoming request.
  always_comb begin
    in_sign_a      = md_a_signed(md.operator_i) & md.operand_a_i[Width-1];
    in_sign_b      = md_b_signed(md.operator_i) & md.operand_b_i[Width-1];
    // Magnitude of the most negative value wraps to itself, which is the right unsigned value.
    in_abs_a       = in_sign_a ? (~md.operand_a_i + 1'b1) : md.operand_a_i;
    in_abs_b       = in_sign_b ? (~md.operand_b_i + 1'b1) : md.operand_b_i;
    in_special     = 1'b0;
    in_special_res = '0;
    if (md_is_div(md.operator_i)) begin
      if (md.operand_b_i == '0) begin
        in_special     = 1'b1;
        in_special_res = md_is_rem(md.operator_i) ? md.operand_a_i : '1;
      end else if (md_a_signed(md.operator_i) && (md.operand_a_i == MinNeg) &&
                   (md.operand_b_i == '1)) begin
        in_special     = 1'b1;
        in_special_res = md_is_rem(md.operator_i) ? '0 : md.operand_a_i;
      end
    end
  end

  // One iteration of shift-add multiply or restoring divide through the shared adder.
  always_comb begin
    is_div   = md_is_div(op_q);
    // Divide: remainder shifted left with the next dividend bit brought in.
    div_cand = acc_q[2*Width-1:Width-1];
    if (is_div) begin
      add_a   = div_cand;
      add_b   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q[2*Width-1:Width]};
      add_b   = {1'b0, opb_q};
      add_cin = 1'b0;
    end
    add_sum = add_a + add_b + {{Width{1'b0}}, add_cin};

    if (is_div) begin
      // Bit Width set means the trial subtract went negative: restore.
      if (add_sum[Width]) begin
        acc_next = {div_cand[Width-1:0], acc_q[Width-2:0], 1'b0};
      end else begin
        acc_next = {add_sum[Width-1:0], acc_q[Width-2:0], 1'b1};
      end
    end else begin
      if (acc_q[0]) begin
        acc_next = {add_sum, acc_q[Width-1:1]};
      end else begin
        acc_next = {1'b0, acc_q[2*Width-1:1]};
      end
    end
  end

  // Sign correction of the finished magnitude and selection of the result word.
  always_comb begin
    neg_res   = sign_a_q ^ sign_b_q;
    product   = neg_res ? (~acc_q + 1'b1) : acc_q;
    quot_mag  = acc_q[Width-1:0];
    rem_mag   = acc_q[2*Width-1:Width];
    quotient  = neg_res ? (~quot_mag + 1'b1) : quot_mag;
    remainder = sign_a_q ? (~rem_mag + 1'b1) : rem_mag;
    unique case (op_q)
      MD_MUL:                      fix_result = product[Width-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result = product[2*Width-1:Width];
      MD_DIV, MD_DIVU:             fix_result = quotient;
      default:                     fix_result = remainder;
    endcase
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (md.valid_i && ready_q) begin
            op_q     <= md.operator_i;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            // Multiplier and dividend both start in the low half.
            acc_q    <= {{Width{1'b0}}, in_abs_a};
            opb_q    <= in_abs_b;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            if (in_special) begin
              result_q <= in_special_res;
              valid_q  <= 1'b1;
              state_q  <= MD_DONE;
            end else begin
              state_q  <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          acc_q <= acc_next;
          if (cnt_q == CntLast) begin
            state_q <= MD_FIX;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        MD_FIX: begin
          result_q <= fix_result;
          valid_q  <= 1'b1;
          state_q  <= MD_DONE;
        end
        MD_DONE: begin
          if (md.ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= MD_IDLE;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panda_muldiv.sv
// Self-checking bench for panda_muldiv: directed cases, random operations against
// an arithmetic reference model, backpressure and mid-operation reset.
module tb_panda_muldiv;
  import panda_muldiv_pkg::*;

  localparam int W = 32;
  localparam int LatNormal = W + 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  panda_muldiv_if #(.Width(W)) bus ();

  panda_muldiv #(.Width(W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .md   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input md_operator_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    if (!(op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU})) return 1'b0;
    if (b == 32'h0) return 1'b1;
    return (op inside {MD_DIV, MD_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Reference: plain 64-bit arithmetic plus the RISC-V divide corner-case rules.
  function automatic logic [31:0] ref_md(input md_operator_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    longint p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      MD_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      MD_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Issue one request, wait for the response, optionally stall in DONE, then release.
  task automatic do_op(input string tag, input md_operator_e op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int exp_lat;
    int lat;
    logic busy_ok;
    logic hold_ok;
    logic [31:0] held;
    exp     = ref_md(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : LatNormal;
    chk({tag, "_ready_idle"}, {31'h0, bus.ready_o}, 32'h1);
    bus.valid_i     = 1'b1;
    bus.operator_i  = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    @(posedge clk); #1;
    bus.valid_i     = 1'b0;
    bus.operator_i  = md_operator_e'($urandom_range(0, 7));
    bus.operand_a_i = $urandom;
    bus.operand_b_i = $urandom;
    lat     = 1;
    busy_ok = 1'b1;
    while (bus.valid_o !== 1'b1 && lat < 100) begin
      if (bus.ready_o !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, bus.result_o, exp);
    chk({tag, "_ready_busy"}, {31'h0, busy_ok & ~bus.ready_o}, 32'h1);
    if (hold > 0) begin
      held    = bus.result_o;
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        bus.valid_i     = $urandom_range(0, 1);
        bus.operator_i  = md_operator_e'($urandom_range(0, 7));
        bus.operand_a_i = $urandom;
        bus.operand_b_i = $urandom;
        @(posedge clk); #1;
        if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.result_o !== held)
          hold_ok = 1'b0;
      end
      chk({tag, "_hold_stable"}, {31'h0, hold_ok}, 32'h1);
      chk({tag, "_hold_result"}, bus.result_o, exp);
      bus.valid_i = 1'b0;
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    chk({tag, "_release"}, {30'h0, bus.valid_o, bus.ready_o}, 32'h1);
  endtask

  initial begin
    md_operator_e rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic pulsed;
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.ready_i     = 1'b0;
    bus.operator_i  = MD_MUL;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {bus.result_o[29:0], bus.valid_o, bus.ready_o}, 32'h1);
    rst = 1'b0;

    do_op("mul_30x3",     MD_MUL,    32'd30,        32'd3,         0);
    do_op("mulh_neg",     MD_MULH,   -32'sd62,      32'd5,         0);
    do_op("mulhu",        MD_MULHU,  32'hFFFF_FFFF, 32'd2,         0);
    do_op("mulhsu",       MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("div_s",        MD_DIV,    -32'sd134,     -32'sd90,      0);
    do_op("rem_s",        MD_REM,    -32'sd134,     -32'sd90,      0);
    do_op("divu",         MD_DIVU,   32'd30,        32'd50,        0);
    do_op("remu",         MD_REMU,   32'd30,        32'd50,        0);
    do_op("div_by_zero",  MD_DIV,    -32'sd12,      32'd0,         0);
    do_op("rem_by_zero",  MD_REM,    -32'sd12,      32'd0,         0);
    do_op("div_ovf",      MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf",      MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("divu_by_zero", MD_DIVU,   32'd77,        32'd0,         0);
    do_op("remu_by_zero", MD_REMU,   32'd77,        32'd0,         0);
    do_op("backpressure", MD_MUL,    32'd1234,      32'd5678,      10);

    // Reset at CALC iteration 10 aborts the operation silently.
    bus.valid_i     = 1'b1;
    bus.operator_i  = MD_MUL;
    bus.operand_a_i = 32'd30;
    bus.operand_b_i = 32'd3;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_state", {bus.result_o[29:0], bus.valid_o, bus.ready_o}, 32'h1);
    chk("midreset_result", bus.result_o, 32'h0);
    pulsed = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.valid_o !== 1'b0) pulsed = 1'b1;
    end
    chk("midreset_no_valid", {31'h0, pulsed}, 32'h0);
    do_op("mul_after_reset", MD_MUL, 32'd7, 32'd6, 0);

    // Random operations, biased towards divide corner cases and small values.
    for (int n = 0; n < 40; n++) begin
      rop = md_operator_e'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 300) - 150; rb = $urandom_range(0, 40) - 20; end
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
